// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the latched request descriptor used by mem2axi.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned AX_ADDR_W = 64;

  typedef struct packed {
    logic [AX_ADDR_W-1:0] addr;
    logic [7:0]           len;
    logic                 we;
  } ax_req_t;

  typedef enum logic [2:0] {
    IDLE,
    SEND_AR,
    RDATA,
    SEND_AW,
    WDATA,
    WAIT_B
  } m2a_state_e;

endpackage

// File: rtl/axi_bus.sv
// Minimal AXI4 bus bundle with Master/Slave views.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  localparam int unsigned NB = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [NB-1:0]             w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/mem2axi.sv
// Simple memory request port to single AXI4 INCR burst bridge, one transaction in flight.
module mem2axi
  import axi_pkg::*;
#(
  parameter int unsigned             AXI_ID_WIDTH   = 10,
  parameter int unsigned             AXI_ADDR_WIDTH = 64,
  parameter int unsigned             AXI_DATA_WIDTH = 64,
  parameter int unsigned             AXI_USER_WIDTH = 10,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID         = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  AXI_BUS.Master                      master,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [7:0]                  len_i,
  input  logic                        wvalid_i,
  output logic                        wready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] wbe_i,
  output logic                        rvalid_o,
  input  logic                        rready_i,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        rlast_o,
  output logic                        done_o,
  output logic                        err_o
);
  localparam int unsigned NB      = AXI_DATA_WIDTH / 8;
  localparam logic [2:0]  AX_SIZE = 3'($clog2(NB));

  m2a_state_e state_q, state_d;
  ax_req_t    ax_q, ax_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  logic ar_valid, aw_valid, w_valid, w_last, r_ready, b_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ax_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ax_q    <= ax_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ax_d     = ax_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    gnt_o    = 1'b0;
    done_o   = 1'b0;
    err_o    = 1'b0;
    wready_o = 1'b0;
    rvalid_o = 1'b0;
    rlast_o  = 1'b0;
    ar_valid = 1'b0;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    w_last   = 1'b0;
    r_ready  = 1'b0;
    b_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          ax_d.addr = AX_ADDR_W'(addr_i & ~AXI_ADDR_WIDTH'(NB - 1));
          ax_d.len  = len_i;
          ax_d.we   = we_i;
          cnt_d     = '0;
          err_d     = 1'b0;
          state_d   = we_i ? SEND_AW : SEND_AR;
        end
      end
      SEND_AR: begin
        ar_valid = 1'b1;
        if (master.ar_ready) state_d = RDATA;
      end
      RDATA: begin
        rvalid_o = master.r_valid;
        rlast_o  = master.r_last;
        r_ready  = rready_i;
        if (master.r_valid && rready_i) begin
          cnt_d = cnt_q + 8'd1;
          err_d = err_q | (master.r_resp != RESP_OKAY);
          if (master.r_last) begin
            // a slave ending the burst early (or late) is reported as an error
            done_o  = 1'b1;
            err_o   = err_d | (cnt_q != ax_q.len);
            state_d = IDLE;
          end
        end
      end
      SEND_AW: begin
        aw_valid = 1'b1;
        if (master.aw_ready) state_d = WDATA;
      end
      WDATA: begin
        w_valid  = wvalid_i;
        wready_o = master.w_ready;
        w_last   = (cnt_q == ax_q.len);
        if (wvalid_i && master.w_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (w_last) state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        b_ready = 1'b1;
        if (master.b_valid) begin
          done_o  = 1'b1;
          err_o   = (master.b_resp != RESP_OKAY);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata_o = master.r_data;

  assign master.ar_valid  = ar_valid;
  assign master.ar_id     = AXI_ID;
  assign master.ar_addr   = AXI_ADDR_WIDTH'(ax_q.addr);
  assign master.ar_len    = ax_q.len;
  assign master.ar_size   = AX_SIZE;
  assign master.ar_burst  = BURST_INCR;
  assign master.ar_lock   = 1'b0;
  assign master.ar_cache  = '0;
  assign master.ar_prot   = '0;
  assign master.ar_qos    = '0;
  assign master.ar_region = '0;
  assign master.ar_user   = '0;

  assign master.aw_valid  = aw_valid;
  assign master.aw_id     = AXI_ID;
  assign master.aw_addr   = AXI_ADDR_WIDTH'(ax_q.addr);
  assign master.aw_len    = ax_q.len;
  assign master.aw_size   = AX_SIZE;
  assign master.aw_burst  = BURST_INCR;
  assign master.aw_lock   = 1'b0;
  assign master.aw_cache  = '0;
  assign master.aw_prot   = '0;
  assign master.aw_qos    = '0;
  assign master.aw_region = '0;
  assign master.aw_user   = '0;

  assign master.w_valid = w_valid;
  assign master.w_data  = wdata_i;
  assign master.w_strb  = wbe_i;
  assign master.w_last  = w_last;
  assign master.w_user  = '0;
  assign master.r_ready = r_ready;
  assign master.b_ready = b_ready;

  logic unused_ok;
  assign unused_ok = ^{master.r_id, master.r_user, master.b_id, master.b_user, ax_q.we};

  // requester must keep each burst inside one 4 KB page
  a_no_4k_cross: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == IDLE && req_i) |->
      (32'(addr_i[11:0]) + (32'(len_i) + 32'd1) * NB) <= 32'd4096);

endmodule

// File: tb/tb_mem2axi.sv
// Requester + AXI slave bench for mem2axi, scored against a byte-addressed memory model.
module tb_mem2axi;
  import axi_pkg::*;

  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0, wvalid_i = 1'b0, rready_i = 1'b0;
  logic [63:0] addr_i = '0, wdata_i = '0;
  logic [7:0]  len_i = '0, wbe_i = '0;
  logic        gnt_o, wready_o, rvalid_o, rlast_o, done_o, err_o;
  logic [63:0] rdata_o;

  int checks = 0;
  int failures = 0;

  logic [63:0] mem     [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];

  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(10)) bus ();

  mem2axi #(
    .AXI_ID_WIDTH(10), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_USER_WIDTH(10), .AXI_ID('0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .master(bus),
    .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .addr_i(addr_i), .len_i(len_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wbe_i(wbe_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rlast_o(rlast_o),
    .done_o(done_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    checks++;
    failures++;
    $error("FAIL %s timeout", tag);
  endtask

  function automatic logic [63:0] dflt(input logic [63:0] a);
    return {~a[31:0], a[31:0]};
  endfunction

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt"}, 64'(gnt_o), 64'd0);
    chk({tag, "_valids"}, 64'({bus.ar_valid, bus.aw_valid, bus.w_valid, rvalid_o, wready_o}), 64'd0);
    chk({tag, "_readies"}, 64'({bus.r_ready, bus.b_ready}), 64'd0);
    chk({tag, "_done_err"}, 64'({done_o, err_o}), 64'd0);
  endtask

  // last_at < 0: slave ends on beat len; rst_beat >= 0: reset while that beat is offered
  task automatic rd_txn(input logic [63:0] addr, input int len, input int ar_dly, input int rr_mode,
                        input int bad_beat, input int rst_beat, input int last_at);
    logic [63:0] base, ar_seen;
    int beat, cyc, lst;
    bit hs, exp_err, fin;
    base = addr & ~64'(NB - 1);
    lst = (last_at < 0) ? len : last_at;
    exp_err = (lst != len);
    req_i = 1'b1; we_i = 1'b0; addr_i = addr; len_i = 8'(len);
    @(negedge clk);
    chk("rd_gnt", 64'(gnt_o), 64'd1);
    chk("rd_ar_early", 64'(bus.ar_valid), 64'd0);
    @(posedge clk); #1;
    req_i = 1'b0;
    ar_seen = '0;
    cyc = 0;
    forever begin
      bus.ar_ready = (cyc >= ar_dly);
      @(negedge clk);
      chk("ar_valid", 64'(bus.ar_valid), 64'd1);
      chk("ar_addr", bus.ar_addr, base);
      chk("ar_len", 64'(bus.ar_len), 64'(len));
      chk("ar_size_burst_id", 64'({bus.ar_size, bus.ar_burst, bus.ar_id}), 64'({3'd3, 2'b01, 10'd0}));
      chk("ar_attr", 64'({bus.ar_lock, bus.ar_cache, bus.ar_prot, bus.ar_qos, bus.ar_region, bus.ar_user}), 64'd0);
      chk("ar_rvalid_o", 64'(rvalid_o), 64'd0);
      ar_seen = bus.ar_addr;
      hs = bus.ar_valid && bus.ar_ready;
      @(posedge clk); #1;
      if (hs) break;
      cyc++;
      if (cyc > 200) begin tmo("ar_handshake"); break; end
    end
    bus.ar_ready = 1'b0;
    beat = 0; cyc = 0; fin = 0;
    while (!fin) begin
      bus.r_valid = ($urandom_range(0, 3) != 0);
      bus.r_data  = mem_rd(ar_seen + 64'(beat * NB));
      bus.r_last  = (beat == lst);
      bus.r_resp  = (beat == bad_beat) ? RESP_SLVERR : RESP_OKAY;
      rready_i    = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (beat == rst_beat && bus.r_valid) begin
        chk("rst_pre_rvalid", 64'(rvalid_o), 64'd1);
        #1 rst_ni = 1'b0;
        #1;
        chk_idle_outputs("rst_mid");
        bus.r_valid = 1'b0; rready_i = 1'b0; bus.r_last = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        return;
      end
      chk("rvalid_o", 64'(rvalid_o), 64'(bus.r_valid));
      chk("r_ready", 64'(bus.r_ready), 64'(rready_i));
      if (bus.r_valid) begin
        chk("rdata", rdata_o, ref_rd(base + 64'(beat * NB)));
        chk("rlast", 64'(rlast_o), 64'(beat == lst));
      end
      hs = bus.r_valid && rready_i;
      if (hs && beat == bad_beat) exp_err = 1'b1;
      if (hs && beat == lst) begin
        chk("rd_done", 64'(done_o), 64'd1);
        chk("rd_err", 64'(err_o), 64'(exp_err));
        fin = 1;
      end else begin
        chk("rd_done_idle", 64'(done_o), 64'd0);
      end
      @(posedge clk); #1;
      if (hs) beat++;
      cyc++;
      if (!fin && cyc > 3000) begin tmo("r_beats"); fin = 1; end
    end
    bus.r_valid = 1'b0; bus.r_last = 1'b0; rready_i = 1'b0;
  endtask

  task automatic wr_txn(input logic [63:0] addr, input int len, input int aw_dly, input int b_dly,
                        input logic [1:0] bresp);
    logic [63:0] base, aw_seen, a;
    logic [63:0] wd[$];
    logic [7:0]  ws[$];
    int beat, cyc;
    bit hs, fin;
    base = addr & ~64'(NB - 1);
    for (int i = 0; i <= len; i++) begin
      wd.push_back({$urandom, $urandom});
      ws.push_back(8'($urandom));
      a = base + 64'(i * NB);
      ref_mem[a] = merge(ref_rd(a), wd[i], ws[i]);
    end
    req_i = 1'b1; we_i = 1'b1; addr_i = addr; len_i = 8'(len);
    wvalid_i = 1'b1; wdata_i = wd[0]; wbe_i = ws[0];
    bus.w_ready = 1'b1;
    @(negedge clk);
    chk("wr_gnt", 64'(gnt_o), 64'd1);
    chk("wr_w_early", 64'({bus.w_valid, wready_o, bus.aw_valid}), 64'd0);
    @(posedge clk); #1;
    req_i = 1'b0;
    aw_seen = '0;
    cyc = 0;
    forever begin
      bus.aw_ready = (cyc >= aw_dly);
      @(negedge clk);
      chk("aw_valid", 64'(bus.aw_valid), 64'd1);
      chk("aw_addr", bus.aw_addr, base);
      chk("aw_len", 64'(bus.aw_len), 64'(len));
      chk("aw_size_burst_id", 64'({bus.aw_size, bus.aw_burst, bus.aw_id}), 64'({3'd3, 2'b01, 10'd0}));
      chk("aw_attr", 64'({bus.aw_lock, bus.aw_cache, bus.aw_prot, bus.aw_qos, bus.aw_region, bus.aw_user}), 64'd0);
      chk("w_during_aw", 64'({bus.w_valid, wready_o}), 64'd0);
      aw_seen = bus.aw_addr;
      hs = bus.aw_valid && bus.aw_ready;
      @(posedge clk); #1;
      if (hs) break;
      cyc++;
      if (cyc > 200) begin tmo("aw_handshake"); break; end
    end
    bus.aw_ready = 1'b0;
    beat = 0; cyc = 0; fin = 0;
    while (!fin) begin
      wvalid_i    = ($urandom_range(0, 2) != 0);
      wdata_i     = wd[beat];
      wbe_i       = ws[beat];
      bus.w_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("w_valid", 64'(bus.w_valid), 64'(wvalid_i));
      chk("wready_o", 64'(wready_o), 64'(bus.w_ready));
      chk("wr_done_idle", 64'(done_o), 64'd0);
      if (wvalid_i) begin
        chk("w_data", bus.w_data, wd[beat]);
        chk("w_strb", 64'(bus.w_strb), 64'(ws[beat]));
        chk("w_last", 64'(bus.w_last), 64'(beat == len));
      end
      hs = bus.w_valid && bus.w_ready;
      if (hs) begin
        a = aw_seen + 64'(beat * NB);
        mem[a] = merge(mem_rd(a), bus.w_data, bus.w_strb);
      end
      @(posedge clk); #1;
      if (hs) begin
        if (beat == len) fin = 1;
        beat++;
      end
      cyc++;
      if (!fin && cyc > 3000) begin tmo("w_beats"); fin = 1; end
    end
    bus.w_ready = 1'b1;
    wvalid_i = 1'b1;
    cyc = 0;
    forever begin
      bus.b_valid = (cyc >= b_dly);
      bus.b_resp  = bresp;
      @(negedge clk);
      chk("b_ready", 64'(bus.b_ready), 64'd1);
      chk("w_after_last", 64'({bus.w_valid, wready_o}), 64'd0);
      if (bus.b_valid) begin
        chk("wr_done", 64'(done_o), 64'd1);
        chk("wr_err", 64'(err_o), 64'(bresp != RESP_OKAY));
      end else begin
        chk("wr_done_wait", 64'(done_o), 64'd0);
      end
      hs = bus.b_valid;
      @(posedge clk); #1;
      if (hs) break;
      cyc++;
      if (cyc > 200) begin tmo("b_handshake"); break; end
    end
    bus.b_valid = 1'b0; bus.w_ready = 1'b0; wvalid_i = 1'b0;
    for (int i = 0; i <= len; i++)
      chk("wr_mem", mem_rd(base + 64'(i * NB)), ref_rd(base + 64'(i * NB)));
  endtask

  initial begin
    #200000000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [63:0] a;
    logic [1:0]  rs;
    int ln, off;
    bus.ar_ready = 1'b0; bus.aw_ready = 1'b0; bus.w_ready = 1'b0;
    bus.b_valid = 1'b0; bus.b_resp = '0; bus.b_id = '0; bus.b_user = '0;
    bus.r_valid = 1'b0; bus.r_data = '0; bus.r_resp = '0; bus.r_last = 1'b0;
    bus.r_id = '0; bus.r_user = '0;
    mem[64'h1000]     = 64'h0000_0000_DEAD_BEEF;
    ref_mem[64'h1000] = 64'h0000_0000_DEAD_BEEF;

    #2;
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;

    rd_txn(64'h1000, 0, 0, 0, -1, -1, -1);
    wr_txn(64'h2000, 7, 2, 1, RESP_OKAY);
    rd_txn(64'h2000, 3, 5, 1, -1, -1, -1);
    wr_txn(64'h3000, 2, 0, 0, RESP_SLVERR);
    rd_txn(64'h1003, 0, 0, 0, -1, -1, -1);
    rd_txn(64'h4000, 3, 1, 2, 1, -1, -1);
    wr_txn(64'h4800, 1, 1, 2, RESP_DECERR);
    rd_txn(64'h5000, 5, 0, 0, -1, -1, 2);
    rd_txn(64'h6000, 3, 0, 0, -1, 2, -1);
    rd_txn(64'h6000, 3, 1, 2, -1, -1, -1);
    wr_txn(64'h7000, 255, 0, 0, RESP_OKAY);
    rd_txn(64'h7000, 255, 0, 0, -1, -1, -1);

    for (int t = 0; t < 24; t++) begin
      ln  = int'($urandom_range(0, 15));
      off = int'($urandom_range(0, 32'(4096 - (ln + 1) * NB)));
      a   = 64'h10000 + 64'($urandom_range(0, 3)) * 64'd4096 + 64'(off);
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0:       rs = RESP_SLVERR;
          1:       rs = RESP_DECERR;
          default: rs = RESP_OKAY;
        endcase
        wr_txn(a, ln, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rs);
      end else begin
        rd_txn(a, ln, int'($urandom_range(0, 3)), 2,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(ln))) : -1, -1, -1);
      end
    end

    @(negedge clk);
    chk_idle_outputs("end_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
